// File: rtl/req_rr_arbiter.sv
// Four-requester arbiter (round-robin or fixed priority); grant one cycle after request, held until done or MAX_HOLD timeout.
// One zero-grant REST cycle separates owners; ARB_XCHECK_EN adds a sticky X/Z request check (xerr).
`timescale 1ns/1ps
module req_rr_arbiter #(
  parameter bit          RR       = 1'b1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
`ifdef ARB_XCHECK_EN
  ,
  output logic       xerr
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, REST} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic       xerr_q, xerr_d;

  logic [3:0] req_vld;
  logic [1:0] scan_base;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       req_x;

  // Only a bit that is strictly 1 counts as a request.
  always_comb begin
    for (int i = 0; i < 4; i++) req_vld[i] = (req[i] === 1'b1);
  end

`ifdef ARB_XCHECK_EN
  assign req_x = ((^req) === 1'bx);
`else
  assign req_x = 1'b0;
`endif

  always_comb begin
    scan_base = 2'd0;
    if (RR) scan_base = (state_q == REST) ? gnt_id_q + 2'd1 : ptr_q;
  end

  // Scan from the highest offset down so the lowest offset from scan_base wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_vld[scan_base + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = scan_base + 2'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    xerr_d     = xerr_q;
    case (state_q)
      IDLE, REST: begin
        if (state_q == REST && RR) ptr_d = gnt_id_q + 2'd1;
        gnt_d  = 4'd0;
        busy_d = 1'b0;
        if (req_x) begin
          xerr_d  = 1'b1;
          state_d = IDLE;
        end else if (win_vld) begin
          gnt_d      = 4'd1 << win_idx;
          gnt_id_d   = win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd0;
          state_d    = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (done) begin
          gnt_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = REST;
        end else if (hold_cnt_q == HOLD_LAST) begin
          gnt_d     = 4'd0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = REST;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 4'd0;
      gnt_id_q   <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
      ptr_q      <= 2'd0;
      xerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
      xerr_q     <= xerr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
`ifdef ARB_XCHECK_EN
  assign xerr    = xerr_q;
`else
  logic unused_xerr;
  assign unused_xerr = xerr_q;
`endif

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Bench for req_rr_arbiter: round-robin (MAX_HOLD=4) and fixed-priority (MAX_HOLD=5) instances share stimulus.
`timescale 1ns/1ps
module tb_req_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_id_a, gnt_id_b;
  logic       busy_a, busy_b;
  logic       timeout_a, timeout_b;
`ifdef ARB_XCHECK_EN
  logic       xerr_a, xerr_b;
`endif

  req_rr_arbiter #(.RR(1'b1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_a), .gnt_id(gnt_id_a), .busy(busy_a), .timeout(timeout_a)
`ifdef ARB_XCHECK_EN
    , .xerr(xerr_a)
`endif
  );

  req_rr_arbiter #(.RR(1'b0), .MAX_HOLD(5)) u_fp (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_b), .gnt_id(gnt_id_b), .busy(busy_b), .timeout(timeout_b)
`ifdef ARB_XCHECK_EN
    , .xerr(xerr_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: owner (-1 = none), cycles held so far including the current one,
  // where the next scan starts, and whether this cycle is a forced-release cycle.
  int m_own[2], m_held[2], m_next[2];
  bit m_to[2];
  int maxh[2] = '{4, 5};
  bit rr_mode[2] = '{1'b1, 1'b0};

  function automatic int pick(input logic [3:0] r, input int base);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (base + k) % 4;
      if (r[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (rst === 1'b1) begin
        m_own[m] = -1; m_held[m] = 0; m_next[m] = 0; m_to[m] = 1'b0;
      end else if (m_own[m] >= 0) begin
        if (done === 1'b1 || m_held[m] == maxh[m]) begin
          m_to[m]   = (done !== 1'b1);
          m_next[m] = rr_mode[m] ? (m_own[m] + 1) % 4 : 0;
          m_own[m]  = -1;
        end else begin
          m_held[m]++;
        end
      end else begin
        int w;
        m_to[m] = 1'b0;
        w = pick(req, m_next[m]);
        if (w >= 0) begin
          m_own[m]  = w;
          m_held[m] = 1;
        end
      end
    end
  endtask

  task automatic compare_one(input int m, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic t);
    string p;
    p = (m == 0) ? "rr" : "fp";
    chk({p, "_gnt"}, int'(g), (m_own[m] >= 0) ? (1 << m_own[m]) : 0);
    chk({p, "_busy"}, int'(b), (m_own[m] >= 0) ? 1 : 0);
    chk({p, "_timeout"}, int'(t), int'(m_to[m]));
    if (m_own[m] >= 0) chk({p, "_gnt_id"}, int'(id), m_own[m]);
  endtask

  task automatic cyc(input logic [3:0] r, input logic d, input logic rs);
    @(negedge clk);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    compare_one(0, gnt_a, gnt_id_a, busy_a, timeout_a);
    compare_one(1, gnt_b, gnt_id_b, busy_b, timeout_b);
  endtask

  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev_a;
    int cnt, cnt2, run, max_run;
    logic [3:0] rq;
    logic [3:0] rx;

    req = 4'd0; done = 1'b0; rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1; m_held[m] = 0; m_next[m] = 0; m_to[m] = 1'b0;
    end

    // Reset state
    cyc(4'd0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b1);
    chk("rst_gnt_id", int'(gnt_id_a), 0);

    // Single request, released by done
    cyc(4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b0, 1'b0);
    chk("single_gnt", int'(gnt_a), 4);
    chk("single_id", int'(gnt_id_a), 2);
    cyc(4'b0100, 1'b1, 1'b0);
    chk("single_rel", int'(gnt_a), 0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Round-robin rotation, owner releases after 2 cycles
    cyc(4'd0, 1'b0, 1'b1);
    prev_a = 4'd0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1111, (m_own[0] >= 0 && m_held[0] == 2), 1'b0);
      if (gnt_a != 4'd0 && prev_a == 4'd0) order.push_back(int'(gnt_id_a));
      if (gnt_a != 4'd0 && prev_a != 4'd0 && gnt_a != prev_a) cnt++;
      prev_a = gnt_a;
    end
    chk("rr_order_len", (order.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5 && i < order.size(); i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    chk("rr_no_direct_switch", cnt, 0);

    // Fixed priority: req[1] always wins over req[3]
    cyc(4'd0, 1'b0, 1'b1);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1010, (m_own[1] >= 0 && m_held[1] == 2), 1'b0);
      if (gnt_b[3]) cnt++;
      if (gnt_b[1]) cnt2++;
    end
    chk("fp_never3", cnt, 0);
    chk("fp_grant1_seen", (cnt2 > 0) ? 1 : 0, 1);

    // Timeout: no done, MAX_HOLD=4 on the round-robin instance
    cyc(4'd0, 1'b0, 1'b1);
    cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0001, 1'b0, 1'b0);
      if (timeout_a) cnt++;
      if (gnt_a[0]) run++; else run = 0;
      if (run > max_run) max_run = run;
    end
    chk("to_pulses", cnt, 2);
    chk("to_hold_len", max_run, 4);

    // done coincides with the last allowed hold cycle: done wins
    cyc(4'd0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(4'b0001, (m_own[0] >= 0 && m_held[0] == 4), 1'b0);
      if (timeout_a) cnt++;
    end
    chk("done_beats_timeout", cnt, 0);

    // Reset while granted
    cyc(4'd0, 1'b0, 1'b1);
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b1);
    chk("rst_mid_gnt", int'(gnt_a), 0);

    // X/Z bit in the request vector is not a request
    cyc(4'd0, 1'b0, 1'b0);
    rx = 4'b0x10;
    cyc(rx, 1'b0, 1'b0);
    cyc(rx, 1'b0, 1'b0);
`ifndef ARB_XCHECK_EN
    chk("xreq_gnt", int'(gnt_a), 2);
`endif
    cyc(4'd0, 1'b0, 1'b1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rq = 4'($urandom_range(0, 15));
      cyc(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
